// File: rtl/commit_sequencer_pkg.sv
// Shared definitions for the commit sequencer.
// - ROB head type encodings as driven by the reorder buffer.
// - Commit FSM state encoding.
// - Datapath widths shared with the register file.
package commit_sequencer_pkg;

  localparam int unsigned InstSize    = 32;
  localparam int unsigned RegAddrSize = 5;
  // Flush counter width; holds FLUSH_CYCLES in the range 1..15.
  localparam int unsigned FlushCntW   = 4;

  typedef enum logic [1:0] {
    RobTypeReg    = 2'b00,
    RobTypeStore  = 2'b01,
    RobTypeBranch = 2'b10,
    RobTypeNowb   = 2'b11
  } rob_type_e;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StWaitStore = 2'b01,
    StFlushWb   = 2'b10,
    StFlush     = 2'b11
  } cs_state_e;

endpackage

// File: rtl/commit_sequencer.sv
// Commit sequencer: retires the ROB head in program order.
// - REG / NOWB / correctly-predicted BRANCH: pop now, register-file write next cycle.
// - STORE: request the LSB, hold the request until st_commit_done, pop on done.
// - Mispredicted BRANCH: pop, link write, then one cycle later clear + redirect,
//   followed by FLUSH_CYCLES quiet cycles before retirement resumes.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable, 0 freezes state)
//   rob_head_*     : ROB head entry description
//   rob_pop        : combinational head-removal strobe
//   rf_wr_*        : registered register-file commit port (port 2)
//   st_commit_*    : registered store request to LSB, st_commit_done from LSB
//   clear          : registered flush pulse
//   redirect_en/pc : registered fetch redirect
//   commit_cnt     : registered retired-instruction counter
module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int unsigned TAG_W        = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_head_valid,
  input  logic                   rob_head_ready,
  input  logic [TAG_W-1:0]       rob_head_tag,
  input  logic [1:0]             rob_head_type,
  input  logic [RegAddrSize-1:0] rob_head_rd,
  input  logic [InstSize-1:0]    rob_head_value,
  input  logic                   rob_head_mispred,
  input  logic [InstSize-1:0]    rob_head_target,
  output logic                   rob_pop,
  output logic                   rf_wr_en,
  output logic [RegAddrSize-1:0] rf_wr_addr,
  output logic [InstSize-1:0]    rf_wr_data,
  output logic [TAG_W-1:0]       rf_wr_tag,
  output logic                   st_commit_req,
  output logic [TAG_W-1:0]       st_commit_tag,
  input  logic                   st_commit_done,
  output logic                   clear,
  output logic                   redirect_en,
  output logic [InstSize-1:0]    redirect_pc,
  output logic [31:0]            commit_cnt
);

  localparam logic [FlushCntW-1:0] FlushInit = FlushCntW'(FLUSH_CYCLES);

  cs_state_e              state_q, state_d;
  logic [FlushCntW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [InstSize-1:0]    target_q, target_d;

  logic                   rf_wr_en_q, rf_wr_en_d;
  logic [RegAddrSize-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [InstSize-1:0]    rf_wr_data_q, rf_wr_data_d;
  logic [TAG_W-1:0]       rf_wr_tag_q, rf_wr_tag_d;
  logic                   st_req_q, st_req_d;
  logic [TAG_W-1:0]       st_tag_q, st_tag_d;
  logic                   clear_q, clear_d;
  logic                   redirect_en_q, redirect_en_d;
  logic [InstSize-1:0]    redirect_pc_q, redirect_pc_d;
  logic [31:0]            commit_cnt_q, commit_cnt_d;

  logic                   pop;
  logic                   head_ok;
  rob_type_e              head_type;

  assign head_ok   = rob_head_valid & rob_head_ready;
  assign head_type = rob_type_e'(rob_head_type);

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    target_d      = target_q;
    rf_wr_en_d    = 1'b0;
    rf_wr_addr_d  = rf_wr_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    rf_wr_tag_d   = rf_wr_tag_q;
    st_req_d      = st_req_q;
    st_tag_d      = st_tag_q;
    clear_d       = 1'b0;
    redirect_en_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    pop           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (head_ok) begin
          if (head_type == RobTypeStore) begin
            // Store is popped only once the LSB confirms it.
            st_req_d = 1'b1;
            st_tag_d = rob_head_tag;
            state_d  = StWaitStore;
          end else begin
            pop = 1'b1;
            if ((head_type != RobTypeNowb) && (rob_head_rd != '0)) begin
              rf_wr_en_d   = 1'b1;
              rf_wr_addr_d = rob_head_rd;
              rf_wr_data_d = rob_head_value;
              rf_wr_tag_d  = rob_head_tag;
            end
            if ((head_type == RobTypeBranch) && rob_head_mispred) begin
              target_d = rob_head_target;
              state_d  = StFlushWb;
            end
          end
        end
      end
      StWaitStore: begin
        if (st_commit_done) begin
          pop      = 1'b1;
          st_req_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StFlushWb: begin
        // One spacer cycle so the link write lands before clear, which the
        // register file would otherwise prioritise over the write.
        clear_d       = 1'b1;
        redirect_en_d = 1'b1;
        redirect_pc_d = target_q;
        flush_cnt_d   = FlushInit;
        state_d       = StFlush;
      end
      StFlush: begin
        if (flush_cnt_q <= FlushCntW'(1)) begin
          flush_cnt_d = '0;
          state_d     = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - FlushCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    commit_cnt_d = pop ? (commit_cnt_q + 32'd1) : commit_cnt_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      flush_cnt_q   <= '0;
      target_q      <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_addr_q  <= '0;
      rf_wr_data_q  <= '0;
      rf_wr_tag_q   <= '0;
      st_req_q      <= 1'b0;
      st_tag_q      <= '0;
      clear_q       <= 1'b0;
      redirect_en_q <= 1'b0;
      redirect_pc_q <= '0;
      commit_cnt_q  <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      target_q      <= target_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_addr_q  <= rf_wr_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_wr_tag_q   <= rf_wr_tag_d;
      st_req_q      <= st_req_d;
      st_tag_q      <= st_tag_d;
      clear_q       <= clear_d;
      redirect_en_q <= redirect_en_d;
      redirect_pc_q <= redirect_pc_d;
      commit_cnt_q  <= commit_cnt_d;
    end
  end

  // Gated by reset too so every output reads 0 while rst_in is high.
  assign rob_pop       = pop & rdy_in & ~rst_in;
  assign rf_wr_en      = rf_wr_en_q;
  assign rf_wr_addr    = rf_wr_addr_q;
  assign rf_wr_data    = rf_wr_data_q;
  assign rf_wr_tag     = rf_wr_tag_q;
  assign st_commit_req = st_req_q;
  assign st_commit_tag = st_tag_q;
  assign clear         = clear_q;
  assign redirect_en   = redirect_en_q;
  assign redirect_pc   = redirect_pc_q;
  assign commit_cnt    = commit_cnt_q;

endmodule
